// File: rtl/peak_readout.sv
// Ping-pong buffer for per-pixel peak bins: captures one frame per peakValid
// strobe into a free bank and streams it out one pixel per valid/ready beat.
module peak_readout #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int FRAME_W           = 8,
    parameter int DROP_W            = 8,
    localparam int PIX_W            = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          peakValid,
    input  logic [NP*PIXEL_NUM_PER_RAM-1:0] peakResult,
    input  logic                          outReady,
    output logic                          outValid,
    output logic [NP-1:0]                 outData,
    output logic [PIX_W-1:0]              outPixel,
    output logic [FRAME_W-1:0]            outFrame,
    output logic                          outLast,
    output logic                          overflow,
    output logic [DROP_W-1:0]             dropCnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [PIX_W-1:0]   LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [PIX_W-1:0]   PIX_ONE  = PIX_W'(1);
    localparam logic [FRAME_W-1:0] SEQ_ONE  = FRAME_W'(1);
    localparam logic [DROP_W-1:0]  DROP_ONE = DROP_W'(1);
    localparam logic [DROP_W-1:0]  DROP_MAX = {DROP_W{1'b1}};

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [1:0]                      r_full;
    logic [1:0]                      w_full_nxt;
    logic                            r_wr_bank;
    logic                            r_rd_bank;
    logic                            w_rd_bank_nxt;
    logic [PIX_W-1:0]                r_pix_idx;
    logic [PIX_W-1:0]                w_pix_nxt;
    logic [FRAME_W-1:0]              r_seq_cnt;
    logic [DROP_W-1:0]               r_drop_cnt;
    logic                            r_overflow;
    logic [NP*PIXEL_NUM_PER_RAM-1:0] r_bank_data [0:1];
    logic [FRAME_W-1:0]              r_bank_tag  [0:1];
    logic [NP*PIXEL_NUM_PER_RAM-1:0] w_rd_word;
    logic [NP-1:0]                   w_rd_pix;

    logic w_hs;
    logic w_free;
    logic w_wr_avail;
    logic w_accept;
    logic w_drop;

    // The bank under the write pointer may be reused in the very cycle its last beat leaves.
    assign w_hs       = (r_state == ST_SEND) & outReady;
    assign w_free     = w_hs & (r_pix_idx == LAST_PIX);
    assign w_wr_avail = ~r_full[r_wr_bank] | (w_free & (r_wr_bank == r_rd_bank));
    assign w_accept   = peakValid & w_wr_avail;
    assign w_drop     = peakValid & ~w_wr_avail;

    // Bank write, frame tagging and write-pointer advance
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_data[b] <= '0;
                r_bank_tag[b]  <= '0;
            end
            r_wr_bank <= 1'b0;
            r_seq_cnt <= '0;
        end else if (w_accept) begin
            r_bank_data[r_wr_bank] <= peakResult;
            r_bank_tag[r_wr_bank]  <= r_seq_cnt;
            r_wr_bank              <= ~r_wr_bank;
            r_seq_cnt              <= r_seq_cnt + SEQ_ONE;
        end else begin
            r_wr_bank <= r_wr_bank;
            r_seq_cnt <= r_seq_cnt;
        end
    end

    // Dropped-frame bookkeeping: saturating count and sticky flag
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_drop_cnt <= (r_drop_cnt == DROP_MAX) ? DROP_MAX : (r_drop_cnt + DROP_ONE);
            r_overflow <= 1'b1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
            r_overflow <= r_overflow;
        end
    end

    // Bank occupancy: a set from a capture wins over a clear from the reader
    always_comb begin
        w_full_nxt = r_full;
        for (int b = 0; b < 2; b++) begin
            if (w_accept && (r_wr_bank == 1'(b))) begin
                w_full_nxt[b] = 1'b1;
            end else if (w_free && (r_rd_bank == 1'(b))) begin
                w_full_nxt[b] = 1'b0;
            end else begin
                w_full_nxt[b] = r_full[b];
            end
        end
    end

    // Occupancy flags register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Read FSM state register with its pixel index and read pointer
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state   <= ST_IDLE;
            r_pix_idx <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_idx <= w_pix_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    // Read FSM next state; a capture landing in the next bank to read starts it without a bubble
    always_comb begin
        w_state_nxt   = r_state;
        w_pix_nxt     = r_pix_idx;
        w_rd_bank_nxt = r_rd_bank;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_bank] || (w_accept && (r_wr_bank == r_rd_bank))) begin
                    w_state_nxt = ST_SEND;
                    w_pix_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_free) begin
                    w_pix_nxt     = '0;
                    w_rd_bank_nxt = ~r_rd_bank;
                    if (r_full[~r_rd_bank] || (w_accept && (r_wr_bank != r_rd_bank))) begin
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_hs) begin
                    w_pix_nxt = r_pix_idx + PIX_ONE;
                end else begin
                    w_pix_nxt = r_pix_idx;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pix_nxt     = '0;
                w_rd_bank_nxt = r_rd_bank;
            end
        endcase
    end

    // Pixel select from the bank under the read pointer
    always_comb begin
        w_rd_word = r_bank_data[r_rd_bank];
        w_rd_pix  = '0;
        for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
            if (r_pix_idx == PIX_W'(p)) begin
                w_rd_pix = w_rd_word[p*NP +: NP];
            end else begin
                w_rd_pix = w_rd_pix;
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        outValid = 1'b0;
        outData  = '0;
        outPixel = '0;
        outFrame = '0;
        outLast  = 1'b0;
        if (r_state == ST_SEND) begin
            outValid = 1'b1;
            outData  = w_rd_pix;
            outPixel = r_pix_idx;
            outFrame = r_bank_tag[r_rd_bank];
            outLast  = (r_pix_idx == LAST_PIX);
        end else begin
            outValid = 1'b0;
        end
    end

    assign overflow = r_overflow;
    assign dropCnt  = r_drop_cnt;

endmodule

// File: doc/peak_readout.md
# peak_readout

Downstream stage of the histogram builder FSM. It captures the per-pixel peak bins the builder publishes for one RAM group and buffers them in a two-bank ping-pong store. It then streams them out one pixel per beat over a valid/ready interface to the readout/interface logic. Frames that arrive while both banks are occupied are dropped and counted, never partially written.

## Interface
Parameters:
- `NP`, 10: width of one peak bin index (matches `Np`).
- `PIXEL_NUM_PER_RAM`, 3: pixels per histogram RAM group, i.e. beats per frame.
- `FRAME_W`, 8: width of frame sequence tag.
- `DROP_W`, 8: width of dropped-frame counter.

Ports:
- `clk`, input, 1: single clock; all logic rising-edge.
- `res`, input, 1: reset, asynchronous, active-low.
- `peakValid`, input, 1: one-cycle strobe from the builder; `peakResult` is valid this cycle.
- `peakResult`, input, NP*PIXEL_NUM_PER_RAM: packed peaks; pixel p occupies bits [p*NP +: NP].
- `outReady`, input, 1: consumer accepts the current beat.
- `outValid`, output, 1: beat available.
- `outData`, output, NP: peak bin of current pixel.
- `outPixel`, output, PIX_W = max(1, clog2(PIXEL_NUM_PER_RAM)): pixel index of the beat.
- `outFrame`, output, FRAME_W: sequence tag of the frame being sent.
- `outLast`, output, 1: high on the beat with `outPixel == PIXEL_NUM_PER_RAM-1`.
- `overflow`, output, 1: sticky; set on the first dropped frame.
- `dropCnt`, output, DROP_W: number of dropped frames, saturating.

## Operation
- Storage: two banks, each holding PIXEL_NUM_PER_RAM × NP bits plus a FRAME_W tag. Each bank has a `full` flag. `wrBank` and `rdBank` pointers reset to 0.
- Capture: on `peakValid`, if bank `wrBank` is not full, or is being freed this cycle, the block:
  - stores `peakResult` into that bank,
  - tags it with `seqCnt`,
  - sets `full`,
  - toggles `wrBank`,
  - increments `seqCnt`, wrapping modulo 2^FRAME_W.
- Drop: on `peakValid` with no bank available, nothing is written and `seqCnt` is unchanged. `dropCnt` increments, saturating at 2^DROP_W-1, and `overflow` is set. `overflow` clears only on reset.
- Read FSM states:
  - IDLE: `outValid`=0. Go to SEND when `full[rdBank]`, with `pixIdx`=0.
  - SEND: `outValid`=1. `outData` = bank[rdBank] pixel `pixIdx`, `outPixel`=`pixIdx`, `outFrame` = bank tag.
    - On `outValid & outReady` with `pixIdx` < last: increment `pixIdx`.
    - On the handshake of the last pixel: clear `full[rdBank]`, toggle `rdBank`, and reset `pixIdx` to 0. Stay in SEND if the other bank is full (no bubble), otherwise go to IDLE.
- Outputs are stable while `outValid & !outReady`. A bank being read is never overwritten.
- A bank freed and a `peakValid` arriving in the same cycle: the capture is accepted into the freed bank; no drop.
- With PIXEL_NUM_PER_RAM=1, every beat has `outLast`=1.

## Timing
- Reset values: `outValid`=0, `outData`=0, `outPixel`=0, `outFrame`=0, `outLast`=0, `overflow`=0, `dropCnt`=0. Internally `seqCnt`=0, both `full`=0, FSM=IDLE.
- Reset assertion mid-stream discards both banks immediately, asynchronously. The first frame after release is tagged 0.
- Latency: `peakValid` at cycle N gives `outValid` high at cycle N+1 when starting from IDLE.
- Throughput: with `outReady` held at 1, a frame takes PIXEL_NUM_PER_RAM cycles. Back-to-back banks stream continuously.
- All outputs are registered or decoded from registered state only. There is no combinational path from `peakValid` or `outReady` to any output.

## Test plan
- Reset then single frame:
  - Stimulus: `peakValid` pulse with pixels {0:108, 1:511, 2:1022}, `outReady`=1.
  - Response: beats in cycles N+1..N+3 carry `outData` 108/511/1022, `outPixel` 0/1/2, `outLast` only on the third beat, `outFrame`=0.
- Backpressure:
  - Stimulus: same frame, `outReady` low for 4 cycles after the first beat.
  - Response: beat 0 (108) is held stable for all stall cycles; the sequence completes unchanged; nothing is dropped.
- Overflow:
  - Stimulus: `outReady`=0, three `peakValid` pulses.
  - Response: frames 0 and 1 are buffered; the third is dropped, with `dropCnt`=1, `overflow`=1, and `seqCnt` staying at 2. Releasing `outReady` yields 6 beats, frames 0 then 1, with no gap between frames.
- Simultaneous free and capture:
  - Stimulus: both banks full; `peakValid` coincides with the last-pixel handshake.
  - Response: the new frame is accepted with tag 2; `dropCnt` stays 0.
- Wrap and saturation:
  - Stimulus: 260 accepted frames.
  - Response: `outFrame` wraps 255→0.
  - Stimulus: 300 drops.
  - Response: `dropCnt` holds at 255.
- Async reset mid-frame:
  - Stimulus: assert `res`=0 after the second beat.
  - Response: `outValid` falls without waiting for a clock edge. After release, a new frame streams with `outFrame`=0 and `outPixel` starting at 0.
